fetch_32: RTL
=============

// Module: fetch_32
// PURPOSE
//  Instruction fetch stage; the producer side of the decode stage's insn_in/insn_pc_in/stall_in interface.
//  Keeps the PC, issues single-outstanding word reads to instruction memory, and buffers returned words in a small FIFO.
//  Presents {instruction, PC, valid} to decode and honours decode's stall.
//  Redirects (jump/branch targets from execute) flush the FIFO and discard any in-flight response.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset
//  BUF_DEPTH  2              prefetch FIFO entries (power of 2, >=2)
// PORTS
//  clk_in            in   1   clock, rising edge
//  reset_in          in   1   asynchronous reset, active-high
//  stall_in          in   1   decode cannot accept; hold current insn_out
//  redirect_in       in   1   PC change (jump/branch taken) this cycle
//  redirect_pc_in    in   32  new PC; bits [1:0] ignored (forced 0)
//  imem_req_out      out  1   read request, held until imem_ack_in
//  imem_addr_out     out  32  word-aligned read address, stable while req high
//  imem_ack_in       in   1   read data valid this cycle, ends request
//  imem_data_in      in   32  instruction word returned with ack
//  insn_out          out  32  instruction to decode (FIFO head)
//  insn_pc_out       out  32  PC of insn_out
//  insn_valid_out    out  1   insn_out/insn_pc_out meaningful
// BEHAVIOUR
//  Reset (async, while reset_in=1): fetch_pc=RESET_PC, FIFO empty, state IDLE, imem_req_out=0, imem_addr_out=0,
//    insn_out=0, insn_pc_out=0, insn_valid_out=0. Reset mid-request abandons it; a late ack is ignored.
//  State machine (one outstanding request):
//    IDLE: if free slots (count + 0) > 0 and no redirect -> assert req, addr=fetch_pc, go REQ.
//    REQ: req held, addr stable. On ack: push {imem_data_in, addr}, fetch_pc += 4, go IDLE.
//         On redirect (without or with same-cycle ack): drop data, go DISCARD if no ack, else IDLE.
//    DISCARD: req held (memory owns the transaction). On ack: data dropped, req deasserts, go IDLE.
//  Issue rule: new request only if FIFO count < BUF_DEPTH (slot reserved for the response); first request is the cycle after reset release.
//  Output: insn_out/insn_pc_out/insn_valid_out are the registered FIFO head; valid = count != 0.
//    Pop when insn_valid_out && !stall_in. Push and pop in one cycle: count unchanged.
//  Latency: ack at cycle N -> insn_valid_out=1 at cycle N+1 (empty FIFO case).
//  Stall: while stall_in=1, outputs hold exactly; fetching continues until FIFO full, then IDLE waits.
//  Redirect (highest priority): same cycle flush FIFO (count=0), fetch_pc=redirect_pc_in & ~3,
//    insn_valid_out=0 from next cycle. Pop and push in the redirect cycle are cancelled.
//    Redirect in DISCARD: only fetch_pc is updated, stay DISCARD. Redirect plus stall: redirect wins.
//  Arithmetic: fetch_pc += 4 mod 2^32; 32'hFFFF_FFFC wraps to 0. FIFO pointers are log2(BUF_DEPTH) bits and wrap;
//    full/empty from separate count of log2(BUF_DEPTH)+1 bits.
//  Ack while IDLE (protocol error): ignored; no push.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: adds port stall_cnt_out out 32 that counts cycles with
//    insn_valid_out && stall_in plus cycles with !insn_valid_out (bubbles). Reset 0, saturates at 32'hFFFF_FFFF, not cleared by redirect.
//  Undefined: port absent, no counter logic; all other behaviour identical.
// TESTING
//  Reset release, imem acks 1 cycle after each req -> addrs 0,4,8...; first insn_valid_out 2 cycles after first req.
//  stall_in=1 for 6 cycles with BUF_DEPTH=2 -> exactly 2 words buffered, req drops, insn_out frozen; release -> in-order 0,4,8.
//  redirect_in with redirect_pc_in=32'h0000_0103 while REQ outstanding -> DISCARD, stale ack dropped, next addr 32'h100, valid only for PC 0x100.
//  Redirect and ack in same cycle -> ack data not delivered; next req addr = redirect target.
//  RESET_PC=32'hFFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  Reset asserted mid-REQ, late ack after release -> ack ignored, first delivered insn has PC RESET_PC; with FETCH_STALL_CNT_EN, stall_cnt_out counts exactly stalled+bubble cycles.

Source files
------------

// File: rtl/fetch_32_if.sv
// Instruction-memory read bus between fetch_32 (master) and instruction memory (slave).
// A request is held with a stable address until the memory returns the word with ack.
interface fetch_32_if;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic [31:0] imem_data_in;

    modport master (
        output imem_req_out,
        output imem_addr_out,
        input  imem_ack_in,
        input  imem_data_in
    );

    modport slave (
        input  imem_req_out,
        input  imem_addr_out,
        output imem_ack_in,
        output imem_data_in
    );
endinterface

// File: rtl/fetch_32.sv
// Instruction fetch stage: single-outstanding imem reads, prefetch FIFO, registered head to decode.
// Optional FETCH_STALL_CNT_EN adds stall_cnt_out, a saturating count of stalled and bubble cycles.
module fetch_32 #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    fetch_32_if.master  imem,
    output logic [31:0] insn_out,
    output logic [31:0] insn_pc_out,
    output logic        insn_valid_out
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_out
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      target_pc;
    logic [31:0]      buf_insn [BUF_DEPTH];
    logic [31:0]      buf_pc   [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             push, pop;
    logic [31:0]      head_insn_nxt, head_pc_nxt;

    assign target_pc  = redirect_pc_in & 32'hFFFF_FFFC;
    assign push       = (state == S_REQ) && imem.imem_ack_in && !redirect_in;
    assign pop        = insn_valid_out && !stall_in && !redirect_in;
    assign rd_ptr_nxt = rd_ptr + PTR_W'(1);
    assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);

    // Next head: the entry behind the popped one, or a bypass of the word arriving now.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        head_insn_nxt = insn_out;
        head_pc_nxt   = insn_pc_out;
        if (pop && count > CNT_W'(1)) begin
            head_insn_nxt = buf_insn[rd_ptr_nxt];
            head_pc_nxt   = buf_pc[rd_ptr_nxt];
        end else if (push && (count == '0 || pop)) begin
            head_insn_nxt = imem.imem_data_in;
            head_pc_nxt   = imem.imem_addr_out;
        end
    end

    // Request FSM; a redirect while a read is in flight waits out the ack in S_DISCARD.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state              <= S_IDLE;
            fetch_pc           <= RESET_PC;
            imem.imem_req_out  <= 1'b0;
            imem.imem_addr_out <= 32'h0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every block sees pre-edge values.
            case (state)
                S_IDLE: begin
                    if (redirect_in) begin
                        fetch_pc <= target_pc;
                    end else if (count < FULL_CNT) begin
                        imem.imem_req_out  <= 1'b1;
                        imem.imem_addr_out <= fetch_pc;
                        state              <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (redirect_in) begin
                        fetch_pc <= target_pc;
                        if (imem.imem_ack_in) begin
                            imem.imem_req_out <= 1'b0;
                            state             <= S_IDLE;
                        end else begin
                            state <= S_DISCARD;
                        end
                    end else if (imem.imem_ack_in) begin
                        imem.imem_req_out <= 1'b0;
                        fetch_pc          <= fetch_pc + 32'd4;
                        state             <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (redirect_in) fetch_pc <= target_pc;
                    if (imem.imem_ack_in) begin
                        imem.imem_req_out <= 1'b0;
                        state             <= S_IDLE;
                    end
                end
                default: begin
                    imem.imem_req_out <= 1'b0;
                    state             <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; count and the valid flag guard every read of it.
    always_ff @(posedge clk_in) begin
        if (push) begin
            buf_insn[wr_ptr] <= imem.imem_data_in;
            buf_pc[wr_ptr]   <= imem.imem_addr_out;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            insn_out       <= 32'h0;
            insn_pc_out    <= 32'h0;
            insn_valid_out <= 1'b0;
        end else if (redirect_in) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            insn_valid_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            count          <= count_nxt;
            insn_valid_out <= (count_nxt != '0);
            insn_out       <= head_insn_nxt;
            insn_pc_out    <= head_pc_nxt;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            stall_cnt_out <= 32'h0;
        end else if ((!insn_valid_out || stall_in) && stall_cnt_out != 32'hFFFF_FFFF) begin
            stall_cnt_out <= stall_cnt_out + 32'd1;
        end
    end
`endif

endmodule
